// File: rtl/ngram_encoder_param.sv
// ngram_encoder_param: temporal N-gram encoder for the HD sensor-fusion path.
// Binds the current spatial hypervector with rotated copies of up to
// NGRAM_MAX-1 earlier samples. N is chosen at run time, and a registered
// valid/ready output stage allows full back-pressure.
//
// Handshake: a sample transfers on an edge where ValidIn_SI & ReadyOut_SO.
// A result transfers on an edge where ValidOut_SO & ReadyIn_SI. A held
// result stays stable until it transfers.
//
// Optional build macro NGRAM_WARMUP_SUPPRESS_EN: results are emitted only
// after enough history has been gathered for the current N. Without it,
// every accepted sample emits and missing history counts as zeros.
module ngram_encoder_param #(
   parameter int HV_DIMENSION = 1000,
   parameter int NGRAM_MAX    = 5,
   parameter int SHIFT_AMT    = 1
) (
   input  logic                             Clk_CI,
   input  logic                             Reset_RBI,
   input  logic                             ValidIn_SI,
   output logic                             ReadyOut_SO,
   input  logic [0:HV_DIMENSION-1]          HypervectorIn_DI,
   input  logic [$clog2(NGRAM_MAX+1)-1:0]   NGramSize_DI,
   input  logic                             Clear_SI,
   output logic                             ValidOut_SO,
   input  logic                             ReadyIn_SI,
   output logic [0:HV_DIMENSION-1]          HypervectorOut_DO,
   output logic                             HistoryFull_SO
);

   localparam int NW = $clog2(NGRAM_MAX + 1);
   localparam int FW = $clog2(NGRAM_MAX);
   localparam int HD = NGRAM_MAX - 1;

   typedef logic [0:HV_DIMENSION-1] hv_t;
   typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} out_state_t;

   // One rotation step: out[i] = v[(i - SHIFT_AMT) mod D].
   function automatic hv_t rho(input hv_t v);
      return {v[HV_DIMENSION-SHIFT_AMT:HV_DIMENSION-1], v[0:HV_DIMENSION-SHIFT_AMT-1]};
   endfunction

   hv_t              hist_q [1:HD];
   hv_t              hist_d [1:HD];
   logic [FW-1:0]    fill_q, fill_d;
   out_state_t       state_q;
   hv_t              out_q;
   logic [NW-1:0]    neff;
   logic             accept;
   logic             emit;
   logic             history_full;
   hv_t              result;

   // Clamp the requested N into 1..NGRAM_MAX.
   always_comb begin
      neff = NGramSize_DI;
      if (NGramSize_DI == '0)
         neff = NW'(1);
      else if (NGramSize_DI > NW'(NGRAM_MAX))
         neff = NW'(NGRAM_MAX);
   end

   assign history_full = (NW'(fill_q) >= (neff - NW'(1)));
   assign ReadyOut_SO  = Reset_RBI & (~ValidOut_SO | ReadyIn_SI);
   assign accept       = ValidIn_SI & ReadyOut_SO;

`ifdef NGRAM_WARMUP_SUPPRESS_EN
   // A sample arriving with Clear_SI counts as the first after a flush.
   assign emit = Clear_SI ? (neff == NW'(1)) : history_full;
`else
   assign emit = 1'b1;
`endif

   // Bind the sample with the pre-update history, limited to the first Neff-1 entries.
   always_comb begin
      result = HypervectorIn_DI;
      if (!Clear_SI) begin
         for (int k = 1; k <= HD; k++) begin
            if (NW'(k) < neff)
               result = result ^ hist_q[k];
         end
      end
   end

   // Next history and fill: shift on accept, flush on clear.
   always_comb begin
      fill_d = fill_q;
      for (int k = 1; k <= HD; k++)
         hist_d[k] = hist_q[k];
      if (accept) begin
         hist_d[1] = rho(HypervectorIn_DI);
         for (int k = 2; k <= HD; k++)
            hist_d[k] = Clear_SI ? '0 : rho(hist_q[k-1]);
         if (Clear_SI)
            fill_d = FW'(1);
         else if (fill_q != FW'(HD))
            fill_d = fill_q + FW'(1);
      end else if (Clear_SI) begin
         for (int k = 1; k <= HD; k++)
            hist_d[k] = '0;
         fill_d = '0;
      end
   end

   // History and fill registers.
   always_ff @(posedge Clk_CI) begin
      if (!Reset_RBI) begin
         for (int k = 1; k <= HD; k++)
            hist_q[k] <= '0;
         fill_q <= '0;
      end else begin
         for (int k = 1; k <= HD; k++)
            hist_q[k] <= hist_d[k];
         fill_q <= fill_d;
      end
   end

   // Output stage FSM: EMPTY / HOLD with a registered result.
   always_ff @(posedge Clk_CI) begin
      if (!Reset_RBI) begin
         state_q <= EMPTY;
         out_q   <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept && emit) begin
                  out_q   <= result;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (ReadyIn_SI) begin
                  if (accept && emit)
                     out_q <= result;
                  else
                     state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign ValidOut_SO       = (state_q == HOLD);
   assign HypervectorOut_DO = out_q;
   assign HistoryFull_SO    = history_full;

endmodule

// File: tb/tb_ngram_encoder_param.sv
// tb_ngram_encoder_param: checks the N-gram encoder against a reference model
// that keeps raw past samples in a queue. It rotates each sample by its age
// with integer arithmetic. Directed cases come first, followed by a random run.
module tb_ngram_encoder_param;

   localparam int HV   = 8;
   localparam int NMAX = 3;
   localparam int SHFT = 1;
   localparam int W    = 8;

   // Clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic            valid_in;
   logic            ready_out;
   logic [0:HV-1]   hv_in;
   logic [1:0]      ngram_size;
   logic            clear;
   logic            valid_out;
   logic            ready_in;
   logic [0:HV-1]   hv_out;
   logic            hist_full;

   ngram_encoder_param #(
      .HV_DIMENSION (HV),
      .NGRAM_MAX    (NMAX),
      .SHIFT_AMT    (SHFT)
   ) dut (
      .Clk_CI            (clk),
      .Reset_RBI         (rst_n),
      .ValidIn_SI        (valid_in),
      .ReadyOut_SO       (ready_out),
      .HypervectorIn_DI  (hv_in),
      .NGramSize_DI      (ngram_size),
      .Clear_SI          (clear),
      .ValidOut_SO       (valid_out),
      .ReadyIn_SI        (ready_in),
      .HypervectorOut_DO (hv_out),
      .HistoryFull_SO    (hist_full)
   );

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] samp_q[$];
   int chk_cnt = 0;
   int err_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Rotate a printed-hex value right by the given number of bit positions.
   function automatic logic [W-1:0] rot(input logic [W-1:0] v, input int k);
      int r;
      r = (k * SHFT) % HV;
      if (r == 0) return v;
      return (v >> r) | (v << (HV - r));
   endfunction

   function automatic int clamp_n(input logic [1:0] n);
      if (n == 0) return 1;
      if (int'(n) > NMAX) return NMAX;
      return int'(n);
   endfunction

   // Driver: apply one cycle of inputs, check against the model, then advance it.
   task automatic step(input logic vin, input logic [W-1:0] x, input logic [1:0] n,
                       input logic clr, input logic rdy, input logic rst);
      logic         exp_ready;
      logic         acc;
      logic         emit;
      logic [W-1:0] res;
      int           neff;
      valid_in   = vin;
      hv_in      = x;
      ngram_size = n;
      clear      = clr;
      ready_in   = rdy;
      rst_n      = rst;
      @(negedge clk);
      neff      = clamp_n(n);
      exp_ready = rst && ((exp_q.size() == 0) || rdy);
      check_val("ready", 32'(ready_out), 32'(exp_ready));
      check_val("valid", 32'(valid_out), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
         check_val("data", 32'(hv_out), 32'(exp_q[0]));
      check_val("hfull", 32'(hist_full), 32'(samp_q.size() >= neff - 1));
      if (!rst) begin
         exp_q.delete();
         samp_q.delete();
      end else begin
         acc = vin && exp_ready;
         if ((exp_q.size() != 0) && rdy)
            void'(exp_q.pop_front());
         if (acc) begin
            res = x;
            if (!clr) begin
               for (int k = 1; k < neff; k++)
                  if (k <= samp_q.size())
                     res = res ^ rot(samp_q[k-1], k);
            end
`ifdef NGRAM_WARMUP_SUPPRESS_EN
            emit = clr ? (neff == 1) : (samp_q.size() >= neff - 1);
`else
            emit = 1'b1;
`endif
            if (emit)
               exp_q.push_back(res);
            if (clr)
               samp_q.delete();
            samp_q.push_front(x);
            if (samp_q.size() > NMAX - 1)
               void'(samp_q.pop_back());
         end else if (clr) begin
            samp_q.delete();
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      valid_in   = 1'b0;
      hv_in      = '0;
      ngram_size = 2'd3;
      clear      = 1'b0;
      ready_in   = 1'b1;
      @(posedge clk);
      #1;
      step(0, 8'h00, 3, 0, 1, 0);
      check_val("rst_valid", 32'(valid_out), 32'd0);
      check_val("rst_data", 32'(hv_out), 32'h00);

      // N=3 with an always-ready sink
      step(1, 8'h80, 3, 0, 1, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("s1_out0", 32'(hv_out), 32'h80);
`else
      check_val("s1_nv0", 32'(valid_out), 32'd0);
`endif
      step(1, 8'h01, 3, 0, 1, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("s1_out1", 32'(hv_out), 32'h41);
`else
      check_val("s1_nv1", 32'(valid_out), 32'd0);
`endif
      step(1, 8'h00, 3, 0, 1, 1);
      check_val("s1_out2", 32'(hv_out), 32'hA0);
      check_val("s1_v2", 32'(valid_out), 32'd1);
      step(0, 8'h00, 3, 0, 1, 1);

      // N=1 bypass, then grow to N=2 reusing the stored sample
      step(0, 8'h00, 1, 0, 1, 0);
      step(1, 8'h5A, 1, 0, 1, 1);
      check_val("n1_out0", 32'(hv_out), 32'h5A);
      step(1, 8'hC3, 1, 0, 1, 1);
      check_val("n1_out1", 32'(hv_out), 32'hC3);
      step(1, 8'h00, 2, 0, 1, 1);
      check_val("n2_out", 32'(hv_out), 32'hE1);
      step(0, 8'h00, 2, 0, 1, 1);

      // Back-pressure: first result held, second sample stalled
      step(0, 8'h00, 3, 0, 1, 0);
      step(1, 8'h80, 3, 0, 0, 1);
      step(1, 8'h01, 3, 0, 0, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("bp_hold", 32'(hv_out), 32'h80);
      check_val("bp_ready", 32'(ready_out), 32'd0);
`endif
      step(1, 8'h01, 3, 0, 1, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("bp_next", 32'(hv_out), 32'h41);
`endif
      step(0, 8'h00, 3, 0, 1, 1);

      // Clear together with an accept
      step(0, 8'h00, 3, 0, 1, 0);
      step(1, 8'h80, 3, 0, 1, 1);
      step(1, 8'h01, 3, 0, 1, 1);
      step(1, 8'h10, 3, 1, 1, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("clr_out", 32'(hv_out), 32'h10);
`endif
      step(1, 8'h00, 3, 0, 1, 1);
`ifndef NGRAM_WARMUP_SUPPRESS_EN
      check_val("clr_next", 32'(hv_out), 32'h08);
`endif

      // Reset while a result is held against a stalled sink
      step(1, 8'h33, 1, 0, 0, 1);
      step(1, 8'h44, 3, 0, 0, 0);
      check_val("mr_valid", 32'(valid_out), 32'd0);
      check_val("mr_data", 32'(hv_out), 32'h00);
      check_val("mr_hfull", 32'(hist_full), 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0),
              8'($urandom_range(0, 255)),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 63) != 0));
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
